// File: rtl/main.sv
// main: single-cycle 8-bit core with PC, 16-word hard-coded ROM, two registers and a combinational ALU.
module main #(
    parameter int ROM_DEPTH = 16,
    parameter int DATA_W = 8,
    parameter logic [ROM_DEPTH*8-1:0] ROM_IMAGE = 128'h00000000000000000000E2A85028D5C3
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              rs,
    output logic              rd,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] PC
);
    localparam int AW = $clog2(ROM_DEPTH);
    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR = 3'd4, OP_XOR = 3'd5, OP_LDI = 3'd6, OP_JMP = 3'd7;
    logic [7:0]        instr;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] regs [2];
    logic              wr;
    assign instr   = ROM_IMAGE[{PC[AW-1:0], 3'b000} +: 8];
    assign opcode  = instr[7:5];
    assign rd      = instr[4];
    assign rs      = instr[3];
    assign imm     = {{(DATA_W-3){1'b0}}, instr[2:0]};
    assign rs_data = regs[rs];
    assign rd_data = regs[rd];
    // NOP and JMP are the only opcodes that leave the register file untouched
    assign wr      = opcode != OP_NOP && opcode != OP_JMP;
    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:         alu_out = rd_data + rs_data;
            OP_SUB:         alu_out = rd_data - rs_data;
            OP_AND:         alu_out = rd_data & rs_data;
            OP_OR:          alu_out = rd_data | rs_data;
            OP_XOR:         alu_out = rd_data ^ rs_data;
            OP_LDI, OP_JMP: alu_out = imm;
            default:        alu_out = '0;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PC      <= '0;
            regs[0] <= '0;
            regs[1] <= '0;
        end else begin
            if (wr) regs[rd] <= alu_out;
            PC <= opcode == OP_JMP ? imm : PC + DATA_W'(1);
        end
    end
endmodule

// File: tb/tb_main.sv
// tb_main: directed checks of the main core against hand-traced program results.
module tb_main;
    logic       CLK = 0;
    logic       RST_N = 0;
    logic       nop_rst_n = 0;
    logic       rs, rd, n_rs, n_rd;
    logic [7:0] rs_data, rd_data, alu_out, PC;
    logic [7:0] n_rs_data, n_rd_data, n_alu_out, n_pc;
    int         total = 0;
    int         bad = 0;

    always #5 CLK = ~CLK;

    main dut (.CLK(CLK), .RST_N(RST_N), .rs(rs), .rd(rd), .rs_data(rs_data),
              .rd_data(rd_data), .alu_out(alu_out), .PC(PC));

    main #(.ROM_IMAGE('0)) nop_dut (.CLK(CLK), .RST_N(nop_rst_n), .rs(n_rs), .rd(n_rd),
              .rs_data(n_rs_data), .rd_data(n_rd_data), .alu_out(n_alu_out), .PC(n_pc));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 0;
        step();
        step();
        total++; if (PC !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", PC); end
        total++; if (rs_data !== 8'h00) begin bad++; $display("FAIL reset_rs_data got=%h exp=00", rs_data); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if ({rd, rs} !== 2'b00) begin bad++; $display("FAIL reset_decode got=%b%b exp=00", rd, rs); end
        total++; if (alu_out !== 8'h03) begin bad++; $display("FAIL reset_alu got=%h exp=03", alu_out); end
    endtask

    task automatic test_load_imm();
        RST_N = 1;
        step();
        total++; if (PC !== 8'h01) begin bad++; $display("FAIL ldi_pc1 got=%h exp=01", PC); end
        total++; if (rd !== 1'b1) begin bad++; $display("FAIL ldi_rd got=%b exp=1", rd); end
        total++; if (alu_out !== 8'h05) begin bad++; $display("FAIL ldi_alu got=%h exp=05", alu_out); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL ldi_r1_before got=%h exp=00", rd_data); end
        step();
        total++; if (PC !== 8'h02) begin bad++; $display("FAIL add_pc got=%h exp=02", PC); end
        total++; if ({rd, rs} !== 2'b01) begin bad++; $display("FAIL add_decode got=%b%b exp=01", rd, rs); end
        total++; if (rs_data !== 8'h05) begin bad++; $display("FAIL add_rs_data got=%h exp=05", rs_data); end
        total++; if (rd_data !== 8'h03) begin bad++; $display("FAIL add_rd_data got=%h exp=03", rd_data); end
        total++; if (alu_out !== 8'h08) begin bad++; $display("FAIL add_alu got=%h exp=08", alu_out); end
    endtask

    task automatic test_arith();
        step();
        total++; if (PC !== 8'h03) begin bad++; $display("FAIL sub_pc got=%h exp=03", PC); end
        total++; if ({rd, rs} !== 2'b10) begin bad++; $display("FAIL sub_decode got=%b%b exp=10", rd, rs); end
        total++; if (rd_data !== 8'h05) begin bad++; $display("FAIL sub_rd_data got=%h exp=05", rd_data); end
        total++; if (rs_data !== 8'h08) begin bad++; $display("FAIL sub_rs_data got=%h exp=08", rs_data); end
        total++; if (alu_out !== 8'hFD) begin bad++; $display("FAIL sub_alu got=%h exp=fd", alu_out); end
        step();
        total++; if (PC !== 8'h04) begin bad++; $display("FAIL xor_pc got=%h exp=04", PC); end
        total++; if (rd_data !== 8'h08) begin bad++; $display("FAIL xor_rd_data got=%h exp=08", rd_data); end
        total++; if (rs_data !== 8'hFD) begin bad++; $display("FAIL xor_rs_data got=%h exp=fd", rs_data); end
        total++; if (alu_out !== 8'hF5) begin bad++; $display("FAIL xor_alu got=%h exp=f5", alu_out); end
    endtask

    task automatic test_jump();
        step();
        total++; if (PC !== 8'h05) begin bad++; $display("FAIL jmp_pc got=%h exp=05", PC); end
        total++; if (alu_out !== 8'h02) begin bad++; $display("FAIL jmp_alu got=%h exp=02", alu_out); end
        step();
        total++; if (PC !== 8'h02) begin bad++; $display("FAIL jmp_target got=%h exp=02", PC); end
        total++; if (rd_data !== 8'hF5) begin bad++; $display("FAIL jmp_r0 got=%h exp=f5", rd_data); end
        total++; if (rs_data !== 8'hFD) begin bad++; $display("FAIL jmp_r1 got=%h exp=fd", rs_data); end
        total++; if (alu_out !== 8'hF2) begin bad++; $display("FAIL add2_alu got=%h exp=f2", alu_out); end
    endtask

    task automatic test_mid_reset();
        step();
        total++; if (alu_out !== 8'h0B) begin bad++; $display("FAIL sub2_alu got=%h exp=0b", alu_out); end
        step();
        total++; if (PC !== 8'h04) begin bad++; $display("FAIL pre_reset_pc got=%h exp=04", PC); end
        total++; if (alu_out !== 8'hF9) begin bad++; $display("FAIL xor2_alu got=%h exp=f9", alu_out); end
        RST_N = 0;
        step();
        total++; if (PC !== 8'h00) begin bad++; $display("FAIL mid_reset_pc got=%h exp=00", PC); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mid_reset_r0 got=%h exp=00", rd_data); end
        total++; if (alu_out !== 8'h03) begin bad++; $display("FAIL mid_reset_alu got=%h exp=03", alu_out); end
        RST_N = 1;
        step();
        total++; if (PC !== 8'h01) begin bad++; $display("FAIL restart_pc got=%h exp=01", PC); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL mid_reset_r1 got=%h exp=00", rd_data); end
        step();
        total++; if (rd_data !== 8'h03) begin bad++; $display("FAIL restart_r0 got=%h exp=03", rd_data); end
        total++; if (rs_data !== 8'h05) begin bad++; $display("FAIL restart_r1 got=%h exp=05", rs_data); end
    endtask

    task automatic test_nop_wrap();
        logic [7:0] exp_pc;
        nop_rst_n = 0;
        step();
        nop_rst_n = 1;
        total++; if (n_pc !== 8'h00) begin bad++; $display("FAIL nop_reset_pc got=%h exp=00", n_pc); end
        exp_pc = 8'h00;
        for (int i = 0; i < 255; i++) begin
            step();
            exp_pc = exp_pc + 8'h01;
            total++; if (n_pc !== exp_pc) begin bad++; $display("FAIL nop_pc got=%h exp=%h", n_pc, exp_pc); end
            total++; if ({n_alu_out, n_rd_data, n_rs_data} !== 24'h0) begin
                bad++; $display("FAIL nop_state got=%h/%h/%h exp=00/00/00", n_alu_out, n_rd_data, n_rs_data);
            end
        end
        total++; if (n_pc !== 8'hFF) begin bad++; $display("FAIL nop_pc_ff got=%h exp=ff", n_pc); end
        step();
        total++; if (n_pc !== 8'h00) begin bad++; $display("FAIL nop_wrap got=%h exp=00", n_pc); end
        total++; if (n_alu_out !== 8'h00) begin bad++; $display("FAIL nop_wrap_alu got=%h exp=00", n_alu_out); end
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_arith();
        test_jump();
        test_mid_reset();
        test_nop_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
